ast_ram_arbiter_sv: RTL and testbench
=====================================

Name: ast_ram_arbiter_sv

Overview:
- Two-requester arbiter for the single-port system data RAM.
- Shares the RAM between the DMA engine and the 2-way data cache, replacing the static dma_busy mux.
- Registered request/grant handshake, round-robin fairness and a burst cap, so the cache is not starved during long tensor transfers.
- Routes read-valid strobes back to the owner of each beat and drives the cache snoop bus on DMA writes.

Parameters:
- DATAWIDTH, 14, width of address and data buses.
- MAX_BURST, 8, maximum consecutive beats an owner keeps the grant while the other requester waits; legal range 1..255.

Ports:
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  synchronous active-low reset
- dma_req  in  1  DMA requests the RAM; held high for the whole burst
- dma_addr  in  DATAWIDTH  DMA beat address
- dma_wdata  in  DATAWIDTH  DMA write data
- dma_wen  in  1  DMA beat is a write
- dma_gnt  out  1  DMA owns the RAM
- dma_rvalid  out  1  rdata holds DMA read result
- cache_req  in  1  cache requests the RAM
- cache_addr  in  DATAWIDTH  cache beat address
- cache_wdata  in  DATAWIDTH  cache write data
- cache_wen  in  1  cache beat is a write
- cache_gnt  out  1  cache owns the RAM
- cache_rvalid  out  1  rdata holds cache read result
- ram_addr  out  DATAWIDTH  RAM address
- ram_data  out  DATAWIDTH  RAM write data
- ram_wren  out  1  RAM write enable
- ram_q  in  DATAWIDTH  RAM read data (registered-address RAM, valid one cycle after the beat)
- rdata  out  DATAWIDTH  ram_q passed through unchanged
- snoop_wen  out  1  DMA write beat this cycle
- snoop_addr  out  DATAWIDTH  DMA write address
- snoop_data  out  DATAWIDTH  DMA write data
- ram_busy  out  1  state is not IDLE

Behaviour:
- States: IDLE, DMA_OWN, CACHE_OWN. Moore grants: dma_gnt = (state==DMA_OWN), cache_gnt = (state==CACHE_OWN).
- Registers: last_owner (1 = DMA), beat_cnt of 8 bits, dma_rvalid, cache_rvalid.
- Reset (resetn low at an edge, including mid-burst): state=IDLE, last_owner=CACHE, beat_cnt=0, both rvalid=0. Any in-flight read strobe is discarded.
- Beat = owner_req & owner_gnt. One RAM access per beat.
- IDLE transitions:
  - only dma_req → DMA_OWN.
  - only cache_req → CACHE_OWN.
  - both requesting → the requester that is not last_owner (first contention after reset goes to DMA).
  - entering an OWN state clears beat_cnt and sets last_owner.
- Grant latency: the req edge is seen at edge t; gnt is high from t+1.
- OWN transitions, evaluated at each edge:
  - owner_req low → IDLE.
  - else other_req high and beat_cnt==MAX_BURST-1 → IDLE; this is a forced release after exactly MAX_BURST beats.
  - else stay, beat_cnt+1 (saturating; counts only while other_req high, otherwise held at 0).
- Handoff: every ownership change passes through IDLE, giving exactly one dead cycle with both gnt low.
- A requester whose gnt drops while req is still high must hold its beat and keep req high. It is re-granted through the normal IDLE arbitration.
- RAM mux (combinational):
  - ram_addr and ram_data come from the owner when the owner's gnt is high, else 0.
  - ram_wren = beat & owner_wen. ram_wren is never 1 in IDLE.
- Read valid: dma_rvalid <= dma beat & !dma_wen; cache_rvalid likewise. Both are one cycle after the beat. At most one is high in any cycle.
- Snoop: snoop_wen = dma beat & dma_wen (combinational). snoop_addr = dma_addr, snoop_data = dma_wdata. Cache writes never drive snoop.
- A req with no gnt produces no RAM activity. wen/addr changes without gnt are ignored.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with both reqs high → both gnt=0, ram_wren=0, ram_busy=0. Release at edge t → dma_gnt=1 at t+1 and cache_gnt=0.
- Solo DMA: dma_req with wen=1 at addresses 0x10..0x13 for 4 beats, cache idle → 4 consecutive writes, snoop_wen=1 on each with matching addr/data, grant held, no dead cycles.
- Cache read: cache_req, wen=0, addr 0x2A; RAM returns 0x155 → cache_rvalid=1 exactly one cycle after the beat with rdata=0x155; dma_rvalid stays 0.
- Burst cap: MAX_BURST=8, DMA streams 20 beats, cache_req rises at DMA beat 3 →
  - DMA releases after beats 3..10 (8 beats) counted from cache_req.
  - one dead cycle, then cache_gnt=1.
  - after the cache drops req, one dead cycle, then DMA resumes at the held address.
- Simultaneous requests: both reqs rise together in IDLE with last_owner=DMA → cache wins. Repeat with last_owner=CACHE → DMA wins.
- Mid-burst reset: resetn=0 during a DMA read burst → next cycle dma_gnt=0, dma_rvalid=0, state IDLE. After release, arbitration restarts with DMA preferred.

Source files
------------

// File: rtl/ast_ram_arbiter_sv.sv
// Two-requester arbiter for the single-port system data RAM (DMA vs. data cache).
// Round-robin with a burst cap; routes read strobes to the beat owner and snoops DMA writes.
module ast_ram_arbiter_sv #(
  parameter int unsigned DATAWIDTH = 14,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 dma_req,
  input  logic [DATAWIDTH-1:0] dma_addr,
  input  logic [DATAWIDTH-1:0] dma_wdata,
  input  logic                 dma_wen,
  output logic                 dma_gnt,
  output logic                 dma_rvalid,
  input  logic                 cache_req,
  input  logic [DATAWIDTH-1:0] cache_addr,
  input  logic [DATAWIDTH-1:0] cache_wdata,
  input  logic                 cache_wen,
  output logic                 cache_gnt,
  output logic                 cache_rvalid,
  output logic [DATAWIDTH-1:0] ram_addr,
  output logic [DATAWIDTH-1:0] ram_data,
  output logic                 ram_wren,
  input  logic [DATAWIDTH-1:0] ram_q,
  output logic [DATAWIDTH-1:0] rdata,
  output logic                 snoop_wen,
  output logic [DATAWIDTH-1:0] snoop_addr,
  output logic [DATAWIDTH-1:0] snoop_data,
  output logic                 ram_busy
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DMA_OWN   = 2'd1,
    CACHE_OWN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               last_owner_q, last_owner_d;  // 1 = DMA owned last
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               dma_rvalid_q, cache_rvalid_q;
  logic               dma_beat, cache_beat;
  logic               owner_req, other_req;

  // State and strobe registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= IDLE;
      last_owner_q   <= 1'b0;
      beat_cnt_q     <= '0;
      dma_rvalid_q   <= 1'b0;
      cache_rvalid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_owner_q   <= last_owner_d;
      beat_cnt_q     <= beat_cnt_d;
      dma_rvalid_q   <= dma_beat & ~dma_wen;
      cache_rvalid_q <= cache_beat & ~cache_wen;
    end
  end

  // Next-state: round-robin in IDLE, release on drop or burst cap while the other waits
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    owner_req    = (state_q == DMA_OWN) ? dma_req : cache_req;
    other_req    = (state_q == DMA_OWN) ? cache_req : dma_req;
    unique case (state_q)
      IDLE: begin
        if (dma_req && (!cache_req || !last_owner_q)) begin
          state_d      = DMA_OWN;
          last_owner_d = 1'b1;
          beat_cnt_d   = '0;
        end else if (cache_req) begin
          state_d      = CACHE_OWN;
          last_owner_d = 1'b0;
          beat_cnt_d   = '0;
        end
      end
      DMA_OWN, CACHE_OWN: begin
        if (!owner_req) begin
          state_d = IDLE;
        end else if (other_req && (beat_cnt_q == CNT_LAST)) begin
          state_d = IDLE;
        end else if (other_req) begin
          beat_cnt_d = (beat_cnt_q == CNT_MAX) ? beat_cnt_q : beat_cnt_q + CNT_W'(1);
        end else begin
          beat_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dma_gnt      = (state_q == DMA_OWN);
  assign cache_gnt    = (state_q == CACHE_OWN);
  assign ram_busy     = (state_q != IDLE);
  assign dma_beat     = dma_gnt & dma_req;
  assign cache_beat   = cache_gnt & cache_req;
  assign dma_rvalid   = dma_rvalid_q;
  assign cache_rvalid = cache_rvalid_q;

  // RAM mux follows the granted owner; nothing reaches the RAM without a grant
  assign ram_addr = dma_gnt ? dma_addr : (cache_gnt ? cache_addr : '0);
  assign ram_data = dma_gnt ? dma_wdata : (cache_gnt ? cache_wdata : '0);
  assign ram_wren = (dma_beat & dma_wen) | (cache_beat & cache_wen);
  assign rdata    = ram_q;

  assign snoop_wen  = dma_beat & dma_wen;
  assign snoop_addr = dma_addr;
  assign snoop_data = dma_wdata;

endmodule

// File: tb/tb_ast_ram_arbiter_sv.sv
// Directed bench for ast_ram_arbiter_sv with a small registered-address RAM model.
module tb_ast_ram_arbiter_sv;

  localparam int unsigned DW = 14;

  logic          clk = 1'b0;
  logic          resetn;
  logic          dma_req, dma_wen, cache_req, cache_wen;
  logic [DW-1:0] dma_addr, dma_wdata, cache_addr, cache_wdata;
  logic          dma_gnt, dma_rvalid, cache_gnt, cache_rvalid;
  logic [DW-1:0] ram_addr, ram_data, ram_q, rdata, snoop_addr, snoop_data;
  logic          ram_wren, snoop_wen, ram_busy;

  logic [DW-1:0] mem [0:255];
  int total = 0;
  int bad   = 0;

  ast_ram_arbiter_sv #(.DATAWIDTH(DW), .MAX_BURST(8)) dut (
    .clk(clk), .resetn(resetn),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_wen(dma_wen),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .cache_req(cache_req), .cache_addr(cache_addr), .cache_wdata(cache_wdata),
    .cache_wen(cache_wen), .cache_gnt(cache_gnt), .cache_rvalid(cache_rvalid),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
    .rdata(rdata), .snoop_wen(snoop_wen), .snoop_addr(snoop_addr),
    .snoop_data(snoop_data), .ram_busy(ram_busy)
  );

  always #5 clk = ~clk;

  // Registered-address RAM; location 0x2A reads back as 0x155
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr[7:0]] <= ram_data;
    ram_q <= (ram_addr == 14'h2A) ? 14'h155 : mem[ram_addr[7:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0;
    dma_req = 1'b1; dma_wen = 1'b0; dma_addr = '0; dma_wdata = '0;
    cache_req = 1'b1; cache_wen = 1'b0; cache_addr = '0; cache_wdata = '0;

    // Reset held three cycles with both requests high
    repeat (3) tick();
    chk1("rst_dma_gnt", dma_gnt, 1'b0);
    chk1("rst_cache_gnt", cache_gnt, 1'b0);
    chk1("rst_wren", ram_wren, 1'b0);
    chk1("rst_busy", ram_busy, 1'b0);
    resetn = 1'b1;
    tick();
    chk1("post_rst_dma_gnt", dma_gnt, 1'b1);
    chk1("post_rst_cache_gnt", cache_gnt, 1'b0);
    dma_req = 1'b0; cache_req = 1'b0;
    tick();
    chk1("idle_busy", ram_busy, 1'b0);

    // Solo DMA write burst 0x10..0x13
    dma_req = 1'b1; dma_wen = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      dma_addr  = 14'h10 + 14'(i);
      dma_wdata = 14'h100 + 14'(i);
      #1;
      chk1("solo_gnt", dma_gnt, 1'b1);
      chk1("solo_wren", ram_wren, 1'b1);
      chk1("solo_snoop_wen", snoop_wen, 1'b1);
      chkw("solo_snoop_addr", snoop_addr, 14'h10 + 14'(i));
      chkw("solo_snoop_data", snoop_data, 14'h100 + 14'(i));
      chkw("solo_ram_addr", ram_addr, 14'h10 + 14'(i));
      chkw("solo_ram_data", ram_data, 14'h100 + 14'(i));
      tick();
    end
    dma_req = 1'b0; dma_wen = 1'b0;
    #1;
    chk1("solo_nobeat_wren", ram_wren, 1'b0);
    tick();
    chk1("solo_done_busy", ram_busy, 1'b0);
    chkw("solo_mem13", mem[8'h13], 14'h103);

    // Cache read from 0x2A
    cache_req = 1'b1; cache_wen = 1'b0; cache_addr = 14'h2A;
    tick();
    chk1("crd_gnt", cache_gnt, 1'b1);
    chkw("crd_addr", ram_addr, 14'h2A);
    chk1("crd_wren", ram_wren, 1'b0);
    chk1("crd_rvalid_early", cache_rvalid, 1'b0);
    tick();
    cache_req = 1'b0;
    chk1("crd_rvalid", cache_rvalid, 1'b1);
    chkw("crd_rdata", rdata, 14'h155);
    chk1("crd_dma_rvalid", dma_rvalid, 1'b0);
    chk1("crd_snoop", snoop_wen, 1'b0);
    tick();
    chk1("crd_rvalid_late", cache_rvalid, 1'b0);
    chk1("crd_idle", ram_busy, 1'b0);

    // Burst cap: DMA streams, cache joins at beat 3, DMA released after beat 10
    dma_req = 1'b1; dma_wen = 1'b1;
    cache_wen = 1'b0; cache_addr = 14'h77;
    tick();
    for (int k = 0; k < 10; k++) begin
      dma_addr  = 14'h40 + 14'(k);
      dma_wdata = 14'h200 + 14'(k);
      if (k == 2) cache_req = 1'b1;
      #1;
      chk1("cap_dma_gnt", dma_gnt, 1'b1);
      chkw("cap_ram_addr", ram_addr, 14'h40 + 14'(k));
      tick();
    end
    dma_addr = 14'h4A; dma_wdata = 14'h20A;
    #1;
    chk1("cap_dead_dma", dma_gnt, 1'b0);
    chk1("cap_dead_cache", cache_gnt, 1'b0);
    chk1("cap_dead_wren", ram_wren, 1'b0);
    chk1("cap_dead_snoop", snoop_wen, 1'b0);
    chkw("cap_dead_addr", ram_addr, 14'h0);
    chkw("cap_mem49", mem[8'h49], 14'h209);
    tick();
    chk1("cap_cache_gnt", cache_gnt, 1'b1);
    chk1("cap_cache_dma_gnt", dma_gnt, 1'b0);
    chkw("cap_cache_addr", ram_addr, 14'h77);
    tick();
    cache_req = 1'b0;
    chk1("cap_cache_rvalid", cache_rvalid, 1'b1);
    tick();
    chk1("cap_dead2_dma", dma_gnt, 1'b0);
    chk1("cap_dead2_cache", cache_gnt, 1'b0);
    tick();
    chk1("cap_resume_gnt", dma_gnt, 1'b1);
    chkw("cap_resume_addr", ram_addr, 14'h4A);
    for (int k = 10; k < 20; k++) begin
      dma_addr  = 14'h40 + 14'(k);
      dma_wdata = 14'h200 + 14'(k);
      #1;
      chk1("cap_tail_gnt", dma_gnt, 1'b1);
      tick();
    end
    dma_req = 1'b0; dma_wen = 1'b0;
    tick();
    chk1("cap_end_busy", ram_busy, 1'b0);
    chkw("cap_mem53", mem[8'h53], 14'h213);

    // Simultaneous requests: last owner DMA, so cache wins
    dma_req = 1'b1; cache_req = 1'b1;
    tick();
    chk1("sim1_cache_gnt", cache_gnt, 1'b1);
    chk1("sim1_dma_gnt", dma_gnt, 1'b0);
    dma_req = 1'b0; cache_req = 1'b0;
    tick();
    dma_req = 1'b1; cache_req = 1'b1;
    tick();
    chk1("sim2_dma_gnt", dma_gnt, 1'b1);
    chk1("sim2_cache_gnt", cache_gnt, 1'b0);
    dma_req = 1'b0; cache_req = 1'b0;
    tick();

    // Mid-burst reset during a DMA read burst
    dma_req = 1'b1; dma_wen = 1'b0; dma_addr = 14'h10;
    tick();
    chk1("mrst_gnt", dma_gnt, 1'b1);
    tick();
    chk1("mrst_rvalid", dma_rvalid, 1'b1);
    chkw("mrst_rdata", rdata, 14'h100);
    resetn = 1'b0; cache_req = 1'b1;
    tick();
    chk1("mrst_dma_gnt", dma_gnt, 1'b0);
    chk1("mrst_dma_rvalid", dma_rvalid, 1'b0);
    chk1("mrst_busy", ram_busy, 1'b0);
    resetn = 1'b1;
    tick();
    chk1("mrst_restart_dma", dma_gnt, 1'b1);
    chk1("mrst_restart_cache", cache_gnt, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
